fifo_write_logic: RTL and testbench
===================================

// Module: fifo_write_logic
// PURPOSE
//  Write side of the router packet FIFO. Accepts a byte stream from the input link and stores each packet in one
//  buffer slot (one slot per FIFO entry). On end-of-packet it writes a length byte and an index-map entry, then
//  advances the write pointer. Publishes the write pointer in Gray code to the read-domain synchronizer. Derives
//  the full flag from the synchronized read pointer.
// PARAMETERS
//  PTR_SZ     2  slot-pointer width; DEPTH = 2**PTR_SZ slots, one kept empty (usable = DEPTH-1)
//  PTR_IN_SZ  4  byte-in-slot index width; slot = 2**PTR_IN_SZ bytes; byte 0 = LEN, byte 1 = DEST_ID
//  UWIDTH     8  data byte width
// PORTS
//  clk            in   1          clock
//  rst            in   1          reset, asynchronous, active-low
//  in_valid       in   1          input beat valid
//  in_sop         in   1          beat is first byte of packet (DEST_ID)
//  in_eop         in   1          beat is last byte of packet
//  in_data        in   UWIDTH     packet byte
//  in_ready       out  1          beat accepted when in_valid && in_ready
//  rq2_rptr_gray  in   PTR_SZ     read pointer, Gray, already 2-flop synchronized
//  uwrite_en      out  1          slot-memory write strobe
//  uaddr          out  PTR_SZ     slot index
//  uaddr_in       out  PTR_IN_SZ  byte index in slot
//  udata_out      out  UWIDTH     slot-memory write data
//  iwrite_en      out  1          index-map write strobe
//  iaddr          out  PTR_SZ     index-map address (= wptr)
//  idata          out  PTR_SZ     index-map data (= slot index = wptr)
//  wptr_gray      out  PTR_SZ     write pointer, Gray, registered
//  full           out  1          combinational: (wptr+1) mod DEPTH == gray2bin(rq2_rptr_gray)
//  pkt_drop       out  1          one-cycle pulse, packet discarded
// BEHAVIOUR
//  Reset: state IDLE; wptr, byte counter, and all outputs 0 (wptr_gray=0, strobes low, pkt_drop low). Any
//   partial packet is lost; reset mid-packet leaves no index-map entry.
//  All outputs except in_ready and full are registered. A beat accepted on cycle N gives uwrite_en on N+1.
//  Byte counter cnt: width PTR_IN_SZ. The k-th accepted byte (k=1..2**PTR_IN_SZ-1) goes to uaddr_in = k,
//   uaddr = wptr.
//  in_ready = (IDLE && !full) || WRITE || DROP; low in COMMIT.
//  FSM:
//   IDLE:   sop beat -> write byte 1, cnt=1. If eop on the same beat -> COMMIT, else -> WRITE.
//           Non-sop beats are accepted and discarded (no pkt_drop).
//   WRITE:  non-sop beat -> cnt+1, write byte cnt+1.
//           Accepting byte 2**PTR_IN_SZ (oversize) -> no write, go DROP; if that beat has eop, pulse pkt_drop
//           and go IDLE.
//           Beat with eop (not oversize) -> COMMIT.
//           Beat with sop -> abort current packet (pkt_drop pulse), restart at byte 1 in the same slot, cnt=1.
//   DROP:   discard beats until eop, then pulse pkt_drop and go IDLE. A sop beat in DROP restarts as in WRITE.
//   COMMIT: one cycle. uwrite_en=1, uaddr_in=0, udata_out=cnt (zero-extended). In the same cycle
//           iwrite_en=1, iaddr=wptr, idata=wptr. wptr <= (wptr+1) mod DEPTH; wptr_gray <= bin2gray(new wptr)
//           on the same edge. -> IDLE.
//  Wrap: wptr wraps DEPTH-1 -> 0. Full is evaluated only at sop acceptance (IDLE); an in-progress packet always
//   completes, because its slot was free when it started.
//  Simultaneous events: the rq2_rptr_gray change that clears full takes effect the same cycle (combinational).
//   in_valid without in_ready holds, and the beat is not consumed.
// CONFIGURATION
//  FIFO_WR_STATS_EN defined: adds output drop_count [7:0]. Reset 0; +1 on every pkt_drop pulse; saturates at
//   255. Not defined: port absent, no counter logic.
// TESTING
//  1. Release rst -> all outputs 0, in_ready=1, full=0, wptr_gray=2'b00.
//  2. Packet 0x80,0xAA,0xBB (sop on 1st, eop on 3rd), rptr=0 -> slot 0 writes at uaddr_in 1,2,3.
//     COMMIT then writes LEN=3 at uaddr_in 0, plus iaddr=0/idata=0; wptr_gray=2'b01.
//  3. rq2_rptr_gray held 0, three 1-byte packets -> full=1 and in_ready=0 after 3rd commit.
//     rq2_rptr_gray=2'b01 -> full=0 the same cycle.
//  4. 16-byte packet -> 15 slot writes, no COMMIT, pkt_drop pulse on eop, wptr_gray unchanged.
//  5. sop mid-packet after 2 bytes, new 4-byte packet -> one pkt_drop; slot 0 committed with LEN=4.
//  6. FIFO_WR_STATS_EN: 2 oversize packets -> drop_count=2; 300 drops -> 255.

Source files
------------

// File: rtl/fifo_write_logic.sv
`default_nettype none
// ============================================================================
// fifo_write_logic : router packet FIFO write side (slot fill, LEN/index commit,
//                    Gray write pointer, full flag). Option: FIFO_WR_STATS_EN
// Revision 1.0
// ============================================================================
module fifo_write_logic #(
  parameter int PTR_SZ    = 2,
  parameter int PTR_IN_SZ = 4,
  parameter int UWIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [UWIDTH-1:0]    in_data,
  output logic                 in_ready,
  input  logic [PTR_SZ-1:0]    rq2_rptr_gray,
  output logic                 uwrite_en,
  output logic [PTR_SZ-1:0]    uaddr,
  output logic [PTR_IN_SZ-1:0] uaddr_in,
  output logic [UWIDTH-1:0]    udata_out,
  output logic                 iwrite_en,
  output logic [PTR_SZ-1:0]    iaddr,
  output logic [PTR_SZ-1:0]    idata,
  output logic [PTR_SZ-1:0]    wptr_gray,
  output logic                 full,
  output logic                 pkt_drop
`ifdef FIFO_WR_STATS_EN
  ,
  output logic [7:0]           drop_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_DROP   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_SZ-1:0]      wptr_q, wptr_d;
  logic [PTR_IN_SZ-1:0]   cnt_q, cnt_d;
  logic                   uwrite_en_q, uwrite_en_d;
  logic [PTR_SZ-1:0]      uaddr_q, uaddr_d;
  logic [PTR_IN_SZ-1:0]   uaddr_in_q, uaddr_in_d;
  logic [UWIDTH-1:0]      udata_q, udata_d;
  logic                   iwrite_en_q, iwrite_en_d;
  logic [PTR_SZ-1:0]      iaddr_q, iaddr_d;
  logic [PTR_SZ-1:0]      wgray_q, wgray_d;
  logic                   pkt_drop_q, pkt_drop_d;

  logic [PTR_SZ-1:0]      rptr_bin;
  logic [PTR_SZ-1:0]      wptr_inc;
  logic [PTR_IN_SZ-1:0]   cnt_inc;
  logic                   accept;
  logic                   oversize;

  always_comb begin
    rptr_bin = '0;
    for (int i = 0; i < PTR_SZ; i++) begin
      rptr_bin[i] = ^(rq2_rptr_gray >> i);
    end
  end

  assign wptr_inc = wptr_q + 1'b1;
  assign cnt_inc  = cnt_q + 1'b1;
  // One slot is always left empty so full/empty stay distinguishable.
  assign full     = (wptr_inc == rptr_bin);
  assign in_ready = ((state_q == S_IDLE) && !full) || (state_q == S_WRITE) || (state_q == S_DROP);
  assign accept   = in_valid && in_ready;
  assign oversize = (cnt_q == '1);

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    uwrite_en_d = 1'b0;
    uaddr_d     = uaddr_q;
    uaddr_in_d  = uaddr_in_q;
    udata_d     = udata_q;
    iwrite_en_d = 1'b0;
    iaddr_d     = iaddr_q;
    wgray_d     = wgray_q;
    pkt_drop_d  = 1'b0;

    if (accept && in_sop) begin
      // A sop outside IDLE abandons the packet in flight and reuses its slot.
      pkt_drop_d  = (state_q != S_IDLE);
      uwrite_en_d = 1'b1;
      uaddr_d     = wptr_q;
      uaddr_in_d  = PTR_IN_SZ'(1);
      udata_d     = in_data;
      cnt_d       = PTR_IN_SZ'(1);
      state_d     = in_eop ? S_COMMIT : S_WRITE;
    end else if (accept) begin
      case (state_q)
        S_WRITE: begin
          if (oversize) begin
            pkt_drop_d = in_eop;
            state_d    = in_eop ? S_IDLE : S_DROP;
          end else begin
            cnt_d       = cnt_inc;
            uwrite_en_d = 1'b1;
            uaddr_d     = wptr_q;
            uaddr_in_d  = cnt_inc;
            udata_d     = in_data;
            if (in_eop) state_d = S_COMMIT;
          end
        end
        S_DROP: begin
          if (in_eop) begin
            pkt_drop_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
        default: ;
      endcase
    end else if (state_q == S_COMMIT) begin
      uwrite_en_d = 1'b1;
      uaddr_d     = wptr_q;
      uaddr_in_d  = '0;
      udata_d     = UWIDTH'(cnt_q);
      iwrite_en_d = 1'b1;
      iaddr_d     = wptr_q;
      wptr_d      = wptr_inc;
      wgray_d     = wptr_inc ^ (wptr_inc >> 1);
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      cnt_q       <= '0;
      uwrite_en_q <= 1'b0;
      uaddr_q     <= '0;
      uaddr_in_q  <= '0;
      udata_q     <= '0;
      iwrite_en_q <= 1'b0;
      iaddr_q     <= '0;
      wgray_q     <= '0;
      pkt_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      uwrite_en_q <= uwrite_en_d;
      uaddr_q     <= uaddr_d;
      uaddr_in_q  <= uaddr_in_d;
      udata_q     <= udata_d;
      iwrite_en_q <= iwrite_en_d;
      iaddr_q     <= iaddr_d;
      wgray_q     <= wgray_d;
      pkt_drop_q  <= pkt_drop_d;
    end
  end

  assign uwrite_en = uwrite_en_q;
  assign uaddr     = uaddr_q;
  assign uaddr_in  = uaddr_in_q;
  assign udata_out = udata_q;
  assign iwrite_en = iwrite_en_q;
  assign iaddr     = iaddr_q;
  assign idata     = iaddr_q;
  assign wptr_gray = wgray_q;
  assign pkt_drop  = pkt_drop_q;

`ifdef FIFO_WR_STATS_EN
  logic [7:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (pkt_drop_d && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_count_q <= 8'd0;
    else      drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_logic.sv
`default_nettype none
// ============================================================================
// tb_fifo_write_logic : randomized scoreboard bench for fifo_write_logic
// Revision 1.0
// ============================================================================
module tb_fifo_write_logic;

  localparam int DEPTH = 4;
  localparam int SLOT  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [1:0] rq2_rptr_gray = 2'b00;
  logic       uwrite_en, iwrite_en, full, pkt_drop;
  logic [1:0] uaddr, iaddr, idata, wptr_gray;
  logic [3:0] uaddr_in;
  logic [7:0] udata_out;
`ifdef FIFO_WR_STATS_EN
  logic [7:0] drop_count;
`endif

  fifo_write_logic dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .in_ready(in_ready), .rq2_rptr_gray(rq2_rptr_gray),
    .uwrite_en(uwrite_en), .uaddr(uaddr), .uaddr_in(uaddr_in), .udata_out(udata_out),
    .iwrite_en(iwrite_en), .iaddr(iaddr), .idata(idata),
    .wptr_gray(wptr_gray), .full(full), .pkt_drop(pkt_drop)
`ifdef FIFO_WR_STATS_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int a; int ai; int d; } wr_t;
  wr_t wq[$];
  int  iq[$];
  int  dq[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Packet-level reference state
  int wptr, rptr, cur_len, dcount;
  bit in_pkt, dropping, commit_pending, auto_drain;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic int bin2gray(int b);
    return (b ^ (b >> 1)) & (DEPTH - 1);
  endfunction

  function automatic void push_drop();
    dq.push_back(1);
    if (dcount < 255) dcount++;
  endfunction

  function automatic void model_accept(bit s, bit e, int d);
    if (s) begin
      if (in_pkt || dropping) push_drop();
      in_pkt = 1; dropping = 0; cur_len = 1;
      wq.push_back('{wptr, 1, d});
      if (e) begin in_pkt = 0; commit_pending = 1; end
    end else if (dropping) begin
      if (e) begin push_drop(); dropping = 0; end
    end else if (in_pkt) begin
      if (cur_len + 1 >= SLOT) begin
        in_pkt = 0;
        if (e) push_drop(); else dropping = 1;
      end else begin
        cur_len++;
        wq.push_back('{wptr, cur_len, d});
        if (e) begin in_pkt = 0; commit_pending = 1; end
      end
    end
  endfunction

  // Called at posedge+1; returns whether the beat was taken at the next edge.
  task automatic step(input bit v, input bit s, input bit e, input int d, output bit acc);
    bit exp_full, exp_ready;
    in_valid = v; in_sop = s; in_eop = e; in_data = d[7:0];
    if (auto_drain && rptr != wptr && $urandom_range(0, 2) == 0) rptr = (rptr + 1) % DEPTH;
    rq2_rptr_gray = 2'(bin2gray(rptr));
    exp_full  = (((wptr + 1) % DEPTH) == rptr);
    exp_ready = commit_pending ? 1'b0 : (!in_pkt && !dropping) ? !exp_full : 1'b1;
    @(negedge clk);
    chk("full", full, exp_full);
    chk("in_ready", in_ready, exp_ready);
    chk("wptr_gray", wptr_gray, bin2gray(wptr));
    @(posedge clk); #1;
    acc = v && exp_ready;
    if (commit_pending) begin
      wq.push_back('{wptr, 0, cur_len});
      iq.push_back(wptr);
      wptr = (wptr + 1) % DEPTH;
      commit_pending = 0;
    end
    if (acc) model_accept(s, e, d);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255), acc);
  endtask

  task automatic send(input bit s, input bit e, input int d);
    bit acc;
    int tries;
    tries = 0;
    do begin
      step(1'b1, s, e, d, acc);
      tries++;
    end while (!acc && tries < 64);
    if (!acc) chk("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pkt(input int len, input bit with_eop);
    for (int i = 0; i < len; i++) send(i == 0, with_eop && (i == len - 1), $urandom_range(0, 255));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h00; rq2_rptr_gray = 2'b00;
    wptr = 0; rptr = 0; cur_len = 0; dcount = 0;
    in_pkt = 0; dropping = 0; commit_pending = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_uwrite_en", uwrite_en, 0);
    chk("rst_iwrite_en", iwrite_en, 0);
    chk("rst_pkt_drop", pkt_drop, 0);
    chk("rst_wptr_gray", wptr_gray, 0);
    chk("rst_uaddr", {uaddr, uaddr_in, udata_out}, 0);
    chk("rst_iaddr_idata", {iaddr, idata}, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_full", full, 0);
    rst = 1'b1;
  endtask

  // Scoreboard monitor
  wr_t mw;
  always @(negedge clk) begin
    if (uwrite_en === 1'b1) begin
      if (wq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL uwrite_unexpected: got addr %0d/%0d data %0h expected no write", uaddr, uaddr_in, udata_out);
      end else begin
        mw = wq.pop_front();
        chk("uaddr", uaddr, mw.a);
        chk("uaddr_in", uaddr_in, mw.ai);
        chk("udata_out", udata_out, mw.d);
      end
    end
    if (iwrite_en === 1'b1) begin
      if (iq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL iwrite_unexpected: got iaddr %0d expected no write", iaddr);
      end else begin
        chk("iaddr", iaddr, iq[0]);
        chk("idata", idata, iq[0]);
        void'(iq.pop_front());
      end
    end
    if (pkt_drop === 1'b1) begin
      chk("pkt_drop_expected", dq.size() > 0, 1);
      if (dq.size() > 0) void'(dq.pop_front());
    end
`ifdef FIFO_WR_STATS_EN
    chk("drop_count", drop_count, dcount);
`endif
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, n;
    bit abort;
    auto_drain = 0;
    do_reset();

    // Three-byte packet into slot 0
    send(1, 0, 8'h80); send(0, 0, 8'hAA); send(0, 1, 8'hBB);
    idle(2);
    chk("t2_wptr_gray", wptr_gray, 2'b01);

    // Fill to full with rptr held at 0, then free one slot
    do_reset();
    for (int p = 0; p < 3; p++) begin
      send(1, 1, $urandom_range(0, 255));
      idle(1);
    end
    idle(1);
    chk("t3_full", full, 1);
    chk("t3_in_ready", in_ready, 0);
    rptr = 1;
    rq2_rptr_gray = 2'b01;
    #1;
    chk("t3_full_clear", full, 0);
    chk("t3_ready_back", in_ready, 1);

    // Oversize packet ending on its 16th byte
    send_pkt(16, 1);
    idle(2);
    chk("t4_wptr_gray", wptr_gray, 2'b10);

    // Mid-packet sop restart
    do_reset();
    auto_drain = 1;
    send(1, 0, 8'h11); send(0, 0, 8'h22);
    send(1, 0, 8'h33); send(0, 0, 8'h44); send(0, 0, 8'h55); send(0, 1, 8'h66);
    idle(2);
    chk("t5_wptr_gray", wptr_gray, 2'b01);

    // Random traffic
    for (int it = 0; it < 250; it++) begin
      if (it == 120) begin
        send(1, 0, 8'h01); send(0, 0, 8'h02); send(0, 0, 8'h03);
        idle(1);
        chk("pre_reset_queues", wq.size() + iq.size() + dq.size(), 0);
        do_reset();
      end
      if ($urandom_range(0, 9) == 0) begin
        if (!in_pkt && !dropping) send(0, $urandom_range(0, 1), $urandom_range(0, 255));
      end else begin
        len   = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 6) : $urandom_range(7, 19);
        abort = ($urandom_range(0, 7) == 0);
        n     = abort ? $urandom_range(1, len) : len;
        send_pkt(n, !abort);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(4);

`ifdef FIFO_WR_STATS_EN
    do_reset();
    send_pkt(16, 1);
    send_pkt(17, 1);
    idle(2);
    chk("t6_drop_count_2", drop_count, 2);
    for (int i = 0; i < 301; i++) send(1, 0, $urandom_range(0, 255));
    send(0, 1, 8'h00);
    idle(4);
    chk("t6_drop_count_sat", drop_count, 255);
`endif

    chk("final_wq_empty", wq.size(), 0);
    chk("final_iq_empty", iq.size(), 0);
    chk("final_dq_empty", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
